// File: rtl/instr_cache.sv
// Direct-mapped, single-word-line instruction cache with a req/ack miss path.
// Define ICACHE_STATS_EN to build the hit/miss counters; otherwise they read 0.
module instr_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDRESS_WIDTH - INDEX_BITS - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]   data_mem [LINES];
    logic [INDEX_BITS-1:0]   index, fill_index;
    logic [TAG_W-1:0]        tag, fill_tag;
    logic                    hit, fill;
    logic                    unused_bits;

    assign index       = cpu_addr[INDEX_BITS+1:2];
    assign tag         = cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    // Fills target the latched request, not the (possibly redirected) PC.
    assign fill_index  = mem_addr[INDEX_BITS+1:2];
    assign fill_tag    = mem_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign unused_bits = ^cpu_addr[1:0];

    assign hit       = (state == IDLE) && valid[index] && (tag_mem[index] == tag);
    assign fill      = (state == FETCH) && mem_ack;
    assign cpu_stall = !hit;
    assign cpu_rdata = hit ? data_mem[index] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            valid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        state             <= IDLE;
                        mem_req           <= 1'b0;
                        valid[fill_index] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Flush overrides a same-edge fill, leaving that line invalid.
            if (flush) valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) hit_count <= hit_count + 32'd1;
            if (state == IDLE && !hit) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: table-driven lookups, directed corner sequences,
// then randomized traffic against a word-address residency model.
module tb_instr_cache;
    logic        clk, rst, cpu_stall, flush, mem_req, mem_ack;
    logic [31:0] cpu_addr, cpu_rdata, mem_addr, mem_rdata, hit_count, miss_count;

    int checks = 0;
    int failures = 0;

    instr_cache dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          k;
        bit          exp_hit;
    } vec_t;

    vec_t tbl[10];

    // Residency model: which word address each index holds.
    logic [31:0] res  [16];
    bit          resv [16];
    bit          busy;
    logic [31:0] req;
    int unsigned mh, mm;

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0) return 32'h00500513;
        return {w[15:0] ^ 16'h5A3C, w[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] stat_exp(input int unsigned v);
`ifdef ICACHE_STATS_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; mem_ack = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One lookup; on a miss, serve it with an ack k cycles after mem_req rises.
    task automatic access(input logic [31:0] a, input int k, input bit exp_hit, input string nm);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        cpu_addr = a;
        #1;
        chk({nm, "_stall"}, {31'd0, cpu_stall}, {31'd0, !exp_hit});
        chk({nm, "_rdata"}, cpu_rdata, exp_hit ? word(a) : 32'h0);
        if (!exp_hit) begin
            chk({nm, "_req_lo"}, {31'd0, mem_req}, 32'd0);
            step;
            chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
            chk({nm, "_maddr"}, mem_addr, wa);
            for (int i = 0; i < k; i++) begin
                step;
                chk({nm, "_req_hold"}, {31'd0, mem_req}, 32'd1);
                chk({nm, "_maddr_hold"}, mem_addr, wa);
                chk({nm, "_stall_hold"}, {31'd0, cpu_stall}, 32'd1);
            end
            mem_ack = 1'b1; mem_rdata = word(a);
            step;
            mem_ack = 1'b0; mem_rdata = $urandom;
            #1;
            chk({nm, "_req_done"}, {31'd0, mem_req}, 32'd0);
            chk({nm, "_refill_stall"}, {31'd0, cpu_stall}, 32'd0);
            chk({nm, "_refill_rdata"}, cpu_rdata, word(a));
        end
        step;
    endtask

    initial begin
        logic [31:0] a, wa;
        logic [25:0] tags [3];
        logic [3:0]  idxs [4];
        bit          hit, ack;
        tags[0] = 26'h0; tags[1] = 26'h1; tags[2] = 26'h3FFFFFF;
        idxs[0] = 4'd0; idxs[1] = 4'd1; idxs[2] = 4'd2; idxs[3] = 4'd15;

        tbl[0] = '{32'h00, 3, 1'b0};  // cold miss
        tbl[1] = '{32'h00, 0, 1'b1};
        tbl[2] = '{32'h02, 0, 1'b1};
        tbl[3] = '{32'h04, 0, 1'b0};
        tbl[4] = '{32'h44, 1, 1'b0};  // conflict at index 1
        tbl[5] = '{32'h04, 2, 1'b0};
        tbl[6] = '{32'h07, 0, 1'b1};
        tbl[7] = '{32'hFFFF_FFFC, 0, 1'b0};
        tbl[8] = '{32'hFFFF_FFFE, 0, 1'b1};
        tbl[9] = '{32'h3C, 0, 1'b0};

        rst = 1'b0; cpu_addr = 32'h0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #2;
        chk("rst_stall", {31'd0, cpu_stall}, 32'd1);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_hits", hit_count, 32'h0);
        chk("rst_misses", miss_count, 32'h0);
        do_reset;

        for (int i = 0; i < 10; i++) access(tbl[i].addr, tbl[i].k, tbl[i].exp_hit, $sformatf("tbl%0d", i));

        // Redirect during FETCH: fill lands at the latched address.
        cpu_addr = 32'h08; #1;
        chk("redir_stall0", {31'd0, cpu_stall}, 32'd1);
        step;
        chk("redir_maddr", mem_addr, 32'h08);
        cpu_addr = 32'h20; #1;
        chk("redir_stall1", {31'd0, cpu_stall}, 32'd1);
        mem_ack = 1'b1; mem_rdata = word(32'h08);
        step;
        mem_ack = 1'b0;
        chk("redir_newmiss", {31'd0, cpu_stall}, 32'd1);
        chk("redir_req_lo", {31'd0, mem_req}, 32'd0);
        step;
        chk("redir_maddr2", mem_addr, 32'h20);
        mem_ack = 1'b1; mem_rdata = word(32'h20);
        step;
        mem_ack = 1'b0;
        chk("redir_hit20", cpu_rdata, word(32'h20));
        cpu_addr = 32'h08; #1;
        chk("redir_hit08_stall", {31'd0, cpu_stall}, 32'd0);
        chk("redir_hit08", cpu_rdata, word(32'h08));
        step;

        // Flush on the ack edge beats the fill.
        cpu_addr = 32'h10; #1;
        step;
        chk("flush_maddr", mem_addr, 32'h10);
        mem_ack = 1'b1; flush = 1'b1; mem_rdata = word(32'h10);
        step;
        mem_ack = 1'b0; flush = 1'b0;
        chk("flush_refill_lost", {31'd0, cpu_stall}, 32'd1);
        cpu_addr = 32'h08; #1;
        chk("flush_08_gone", {31'd0, cpu_stall}, 32'd1);
        access(32'h08, 0, 1'b0, "flush_08");

        // Reset mid-FETCH, stale ack, then stats sequence miss/hit/hit/miss.
        cpu_addr = 32'h18; #1;
        step;
        chk("mrst_req_hi", {31'd0, mem_req}, 32'd1);
        #2; rst = 1'b0; #1;
        chk("mrst_req_async", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; cpu_addr = 32'h08; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("mrst_stale_stall", {31'd0, cpu_stall}, 32'd1);
        chk("mrst_maddr", mem_addr, 32'h0);
        step;
        mem_ack = 1'b0;
        chk("mrst_refetch_req", {31'd0, mem_req}, 32'd1);
        chk("mrst_refetch_addr", mem_addr, 32'h08);
        mem_ack = 1'b1; mem_rdata = word(32'h08);
        step;
        mem_ack = 1'b0;
        chk("mrst_hit_data", cpu_rdata, word(32'h08));
        step;
        step;
        cpu_addr = 32'h44; #1;
        chk("stats_hits_a", hit_count, stat_exp(2));
        chk("stats_misses_a", miss_count, stat_exp(1));
        step;
        chk("stats_hits", hit_count, stat_exp(2));
        chk("stats_misses", miss_count, stat_exp(2));

        // Randomized traffic against the residency model.
        do_reset;
        for (int i = 0; i < 16; i++) resv[i] = 1'b0;
        busy = 1'b0; req = 32'h0; mh = 0; mm = 0;
        a = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) != 0)
                a = {tags[$urandom_range(0, 2)], idxs[$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
            cpu_addr = a;
            wa = {a[31:2], 2'b00};
            flush = ($urandom_range(0, 39) == 0);
            ack = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            mem_ack = ack;
            mem_rdata = (ack && busy) ? word(req) : $urandom;
            #1;
            hit = !busy && resv[a[5:2]] && (res[a[5:2]] == wa);
            chk("rnd_stall", {31'd0, cpu_stall}, {31'd0, !hit});
            chk("rnd_rdata", cpu_rdata, hit ? word(a) : 32'h0);
            chk("rnd_req", {31'd0, mem_req}, {31'd0, busy});
            if (busy) chk("rnd_maddr", mem_addr, req);
            chk("rnd_hits", hit_count, stat_exp(mh));
            chk("rnd_misses", miss_count, stat_exp(mm));
            if (hit) mh++;
            if (!busy && !hit) begin
                busy = 1'b1; req = wa; mm++;
            end else if (busy && ack) begin
                res[req[5:2]] = req; resv[req[5:2]] = 1'b1; busy = 1'b0;
            end
            if (flush) for (int i = 0; i < 16; i++) resv[i] = 1'b0;
            step;
        end
        mem_ack = 1'b0; flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
